snoop_resp_collector: RTL and testbench
=======================================

Name: snoop_resp_collector

Overview:
Sits directly downstream of the 4-core coherency bus. Captures each broadcast transaction, gathers per-core snoop responses from the non-requesting cores, and returns one combined response (shared/dirty/owner) to the requester. A timeout bounds waiting on missing responses. Flags overlapping broadcasts and illegal multi-dirty responses.

Parameters:
NUM_CORES, 4, number of snooping cores; design is fixed at 4 and the core id is 2 bits wide.
ADDR_WIDTH, 64, transaction address width.
TIMEOUT_CYCLES, 16, number of COLLECT cycles allowed before a forced timeout response; must be at least 1.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
bus_valid  in  1  broadcast valid from the bus; held high for several cycles per transaction
bus_addr  in  ADDR_WIDTH  broadcast address
bus_type  in  1  broadcast request type
granted_core_id  in  2  requesting core
snp_valid  in  NUM_CORES  per-core snoop response valid, one-cycle pulse
snp_shared  in  NUM_CORES  per-core: line held
snp_dirty  in  NUM_CORES  per-core: line held modified
resp_valid  out  1  combined response, one-cycle pulse
resp_core_id  out  2  requester the response is for
resp_addr  out  ADDR_WIDTH  captured address
resp_type  out  1  captured type
resp_shared  out  1  OR of shared over responders
resp_dirty  out  1  any responder dirty
resp_owner_id  out  2  dirty responder id; 0 if none
resp_timeout  out  1  response forced by timeout
err_multi_dirty  out  1  sticky: more than one dirty responder in one transaction
err_overrun  out  1  sticky: new broadcast started while busy

Behaviour:
- Reset, checked on the clk edge while rst_n=0: state=IDLE. All outputs, both sticky flags, and all internal masks, counters and the bus_valid_q register are 0. Reset mid-transaction discards the transaction and emits no response.
- Start event: bus_valid && !bus_valid_q, where bus_valid_q is bus_valid registered by one cycle.
- FSM states:
  - IDLE:
    - On a start event, capture addr, type and core id.
    - Set expected = all cores except the requester (4'b1111 with bit granted_core_id cleared).
    - Clear received, shared_acc, dirty_acc and owner.
    - Load timer = TIMEOUT_CYCLES, then go to COLLECT.
    - snp_valid is ignored in IDLE.
  - COLLECT: each cycle, for every core i with snp_valid[i] && expected[i] && !received[i]:
    - set received[i];
    - OR snp_shared[i] into shared_acc.
    - If snp_dirty[i]: if dirty_acc is already set, or several dirty responses arrive in the same cycle, set err_multi_dirty. owner = lowest-index new dirty responder, unless owner is already set. Then set dirty_acc.
    - Responses from the requester, duplicate responses, and responses from cores already received are ignored.
    - Let received_next be received including this cycle's new bits. If received_next == expected, go to RESP.
    - Otherwise timer decrements; if timer was 1, go to RESP with timeout=1.
    - Completion wins over timeout in the same cycle.
  - RESP:
    - resp_valid=1 for exactly this cycle.
    - resp_* are driven from the captured and accumulated values and hold those values after the pulse until the next RESP.
    - Return to IDLE.
- Latency:
  - Start event at cycle T; COLLECT from T+1.
  - If all responses arrive at T+1, resp_valid=1 at T+2.
  - With no responses, timeout resp_valid=1 at T+1+TIMEOUT_CYCLES.
- A start event seen in COLLECT or RESP sets err_overrun; that transaction is dropped. A start event in the RESP cycle is also dropped; a new transaction is accepted only from IDLE.
- The sticky error flags clear only on reset.

Optional Feature:
Macro SNOOP_COLLECT_PERF_EN.
- Defined: adds 32-bit outputs perf_txn_cnt (increments on each resp_valid), perf_timeout_cnt (increments on resp_valid && resp_timeout) and perf_dirty_cnt (increments on resp_valid && resp_dirty). All three wrap at 2^32, reset to 0 and do not saturate.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package coh_pkg:
  - typedef core_id_t (logic [1:0]);
  - NUM_CORES constant;
  - snoop FSM enum snp_state_t {IDLE, COLLECT, RESP};
  - struct snp_resp_t {shared, dirty, owner_id, timeout}.
- One sub-module, snp_timeout_timer: load/decrement/expire counter sized $clog2(TIMEOUT_CYCLES+1).
- Mask accumulation and the FSM stay in the top module.

Test Plan:
- Core 1 broadcast at T; cores 0, 2, 3 snp_valid at T+1 with shared=4'b0100 and dirty=0 -> resp_valid at T+2 with resp_core_id=1, resp_shared=1, resp_dirty=0, resp_timeout=0.
- Core 0 broadcast at addr 0x1000; core 3 responds dirty at T+2, cores 1 and 2 respond clean at T+4 -> resp_valid at T+5 with resp_dirty=1, resp_owner_id=3, resp_addr=0x1000.
- Core 2 broadcast; only core 0 responds; TIMEOUT_CYCLES=16 -> resp_valid at T+17 with resp_timeout=1.
- Cores 1 and 3 both respond dirty in the same cycle -> err_multi_dirty=1 and resp_owner_id=1; a later clean transaction leaves err_multi_dirty=1.
- bus_valid drops and rises again while in COLLECT -> err_overrun=1; only one resp_valid is produced. Requester's own snp_valid has no effect.
- rst_n=0 for 1 cycle mid-COLLECT -> no resp_valid, all outputs 0. A fresh transaction then completes normally.

Source files
------------

// File: rtl/coh_pkg.sv
// Shared coherency-bus types for the snoop response collector.
// Provides the core id type, the fixed core count, the collector FSM
// states, the combined response record and two small mask helpers.
package coh_pkg;

    localparam int NUM_CORES = 4;

    typedef logic [1:0] core_id_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESP    = 2'd2
    } snp_state_t;

    typedef struct packed {
        logic     shared;
        logic     dirty;
        core_id_t owner_id;
        logic     timeout;
    } snp_resp_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic core_id_t lowest_core(input logic [NUM_CORES-1:0] mask);
        core_id_t id;
        id = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                id = core_id_t'(i);
            end
        end
        return id;
    endfunction

    // True when more than one bit of the mask is set.
    function automatic logic multi_hot(input logic [NUM_CORES-1:0] mask);
        logic [NUM_CORES-1:0] one;
        one = {{(NUM_CORES-1){1'b0}}, 1'b1};
        return (mask & (mask - one)) != '0;
    endfunction

endpackage

// File: rtl/snp_timeout_timer.sv
// Response-wait timer for the snoop collector.
// Loaded with TIMEOUT_CYCLES when a transaction is accepted, decremented
// once per waiting cycle; o_expire flags the final allowed cycle so the
// owner can force a response on that same edge.
module snp_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    // Load on accept, count down while waiting, park at zero otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/snoop_resp_collector.sv
// Snoop response collector for the 4-core coherency bus.
// Captures a broadcast, waits for snoop responses from every core except
// the requester (bounded by a timeout), then pulses one combined
// shared/dirty/owner response. Sticky flags report overlapping broadcasts
// and more than one dirty responder in a transaction.
// Optional: define SNOOP_COLLECT_PERF_EN to add 32-bit wrapping counters of
// responses, timed-out responses and dirty responses.
module snoop_resp_collector
    import coh_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_valid,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_type,
    input  logic [1:0]            granted_core_id,
    input  logic [NUM_CORES-1:0]  snp_valid,
    input  logic [NUM_CORES-1:0]  snp_shared,
    input  logic [NUM_CORES-1:0]  snp_dirty,
    output logic                  resp_valid,
    output logic [1:0]            resp_core_id,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  resp_type,
    output logic                  resp_shared,
    output logic                  resp_dirty,
    output logic [1:0]            resp_owner_id,
    output logic                  resp_timeout,
    output logic                  err_multi_dirty,
    output logic                  err_overrun
`ifdef SNOOP_COLLECT_PERF_EN
    ,
    output logic [31:0]           perf_txn_cnt,
    output logic [31:0]           perf_timeout_cnt,
    output logic [31:0]           perf_dirty_cnt
`endif
);

    // ------------------------------------------------------------------
    // State and captured transaction
    // ------------------------------------------------------------------
    snp_state_t            r_state;
    snp_state_t            w_state_next;
    logic                  r_bus_valid_q;
    core_id_t              r_req_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_type;
    logic [NUM_CORES-1:0]  r_expected;
    logic [NUM_CORES-1:0]  r_received;
    logic                  r_shared_acc;
    logic                  r_dirty_acc;
    core_id_t              r_owner;

    // Registered response outputs, held between responses
    logic                  r_resp_valid;
    core_id_t              r_resp_core_id;
    logic [ADDR_WIDTH-1:0] r_resp_addr;
    logic                  r_resp_type;
    snp_resp_t             r_resp;
    logic                  r_err_multi_dirty;
    logic                  r_err_overrun;

    // Combinational helpers
    logic                  w_start;
    logic                  w_collecting;
    logic [NUM_CORES-1:0]  w_expected_init;
    logic [NUM_CORES-1:0]  w_new;
    logic [NUM_CORES-1:0]  w_new_dirty;
    logic [NUM_CORES-1:0]  w_received_next;
    logic                  w_all_in;
    logic                  w_shared_next;
    logic                  w_dirty_next;
    core_id_t              w_owner_next;
    logic                  w_multi_dirty_hit;
    logic                  w_load;
    logic                  w_dec;
    logic                  w_expire;
    logic                  w_enter_resp;
    logic                  w_timeout;

    // A start is a rising edge of bus_valid, since the bus holds it high
    // for several cycles per transaction.
    assign w_start      = bus_valid & ~r_bus_valid_q;
    assign w_collecting = (r_state == COLLECT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            // Everyone but the requester owes a response.
            assign w_expected_init[gi] = (granted_core_id != core_id_t'(gi));
            // Only first responses from expected cores count.
            assign w_new[gi]       = w_collecting & snp_valid[gi] & r_expected[gi] & ~r_received[gi];
            assign w_new_dirty[gi] = w_new[gi] & snp_dirty[gi];
        end
    endgenerate

    assign w_received_next = r_received | w_new;
    assign w_all_in        = (w_received_next == r_expected);
    assign w_shared_next   = r_shared_acc | (|(w_new & snp_shared));
    assign w_dirty_next    = r_dirty_acc | (|w_new_dirty);
    // The first dirty responder keeps ownership; among simultaneous new
    // dirty responders the lowest index wins.
    assign w_owner_next    = r_dirty_acc ? r_owner : lowest_core(w_new_dirty);
    assign w_multi_dirty_hit = (|w_new_dirty) & (r_dirty_acc | multi_hot(w_new_dirty));

    snp_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_dec    (w_dec),
        .o_expire (w_expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; completion takes priority over timeout
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_enter_resp = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_load       = 1'b1;
                    w_state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (w_all_in) begin
                    w_enter_resp = 1'b1;
                    w_state_next = RESP;
                end else begin
                    w_dec = 1'b1;
                    if (w_expire) begin
                        w_enter_resp = 1'b1;
                        w_timeout    = 1'b1;
                        w_state_next = RESP;
                    end
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Transaction capture in IDLE and response accumulation in COLLECT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bus_valid_q <= 1'b0;
            r_req_id      <= '0;
            r_addr        <= '0;
            r_type        <= 1'b0;
            r_expected    <= '0;
            r_received    <= '0;
            r_shared_acc  <= 1'b0;
            r_dirty_acc   <= 1'b0;
            r_owner       <= '0;
        end else begin
            r_bus_valid_q <= bus_valid;
            if ((r_state == IDLE) && w_start) begin
                r_req_id     <= granted_core_id;
                r_addr       <= bus_addr;
                r_type       <= bus_type;
                r_expected   <= w_expected_init;
                r_received   <= '0;
                r_shared_acc <= 1'b0;
                r_dirty_acc  <= 1'b0;
                r_owner      <= '0;
            end else if (w_collecting) begin
                r_received   <= w_received_next;
                r_shared_acc <= w_shared_next;
                r_dirty_acc  <= w_dirty_next;
                r_owner      <= w_owner_next;
            end
        end
    end

    // Response outputs load on the edge into RESP so they are valid during
    // the RESP cycle and hold afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid   <= 1'b0;
            r_resp_core_id <= '0;
            r_resp_addr    <= '0;
            r_resp_type    <= 1'b0;
            r_resp         <= '0;
        end else begin
            r_resp_valid <= w_enter_resp;
            if (w_enter_resp) begin
                r_resp_core_id  <= r_req_id;
                r_resp_addr     <= r_addr;
                r_resp_type     <= r_type;
                r_resp.shared   <= w_shared_next;
                r_resp.dirty    <= w_dirty_next;
                r_resp.owner_id <= w_owner_next;
                r_resp.timeout  <= w_timeout;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_multi_dirty <= 1'b0;
            r_err_overrun     <= 1'b0;
        end else begin
            if (w_multi_dirty_hit) begin
                r_err_multi_dirty <= 1'b1;
            end
            if (w_start && (r_state != IDLE)) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    assign resp_valid      = r_resp_valid;
    assign resp_core_id    = r_resp_core_id;
    assign resp_addr       = r_resp_addr;
    assign resp_type       = r_resp_type;
    assign resp_shared     = r_resp.shared;
    assign resp_dirty      = r_resp.dirty;
    assign resp_owner_id   = r_resp.owner_id;
    assign resp_timeout    = r_resp.timeout;
    assign err_multi_dirty = r_err_multi_dirty;
    assign err_overrun     = r_err_overrun;

`ifdef SNOOP_COLLECT_PERF_EN
    logic [31:0] r_perf_txn_cnt;
    logic [31:0] r_perf_timeout_cnt;
    logic [31:0] r_perf_dirty_cnt;

    // Free-running wrapping event counters driven by the response pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_txn_cnt     <= '0;
            r_perf_timeout_cnt <= '0;
            r_perf_dirty_cnt   <= '0;
        end else if (r_resp_valid) begin
            r_perf_txn_cnt <= r_perf_txn_cnt + 32'd1;
            if (r_resp.timeout) begin
                r_perf_timeout_cnt <= r_perf_timeout_cnt + 32'd1;
            end
            if (r_resp.dirty) begin
                r_perf_dirty_cnt <= r_perf_dirty_cnt + 32'd1;
            end
        end
    end

    assign perf_txn_cnt     = r_perf_txn_cnt;
    assign perf_timeout_cnt = r_perf_timeout_cnt;
    assign perf_dirty_cnt   = r_perf_dirty_cnt;
`endif

endmodule

// File: tb/tb_snoop_resp_collector.sv
`timescale 1ns/1ps
`define CHK(nm, act, exp) chk(nm, 64'(act), 64'(exp))

module tb_snoop_resp_collector;
    import coh_pkg::*;

    localparam int AW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bus_valid;
    logic [AW-1:0] bus_addr;
    logic          bus_type;
    logic [1:0]    granted_core_id;
    logic [3:0]    snp_valid, snp_shared, snp_dirty;
    logic          resp_valid;
    logic [1:0]    resp_core_id;
    logic [AW-1:0] resp_addr;
    logic          resp_type, resp_shared, resp_dirty;
    logic [1:0]    resp_owner_id;
    logic          resp_timeout, err_multi_dirty, err_overrun;
`ifdef SNOOP_COLLECT_PERF_EN
    logic [31:0]   perf_txn_cnt, perf_timeout_cnt, perf_dirty_cnt;
`endif

    always #5 clk = ~clk;

    snoop_resp_collector #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_addr(bus_addr),
        .bus_type(bus_type), .granted_core_id(granted_core_id),
        .snp_valid(snp_valid), .snp_shared(snp_shared), .snp_dirty(snp_dirty),
        .resp_valid(resp_valid), .resp_core_id(resp_core_id), .resp_addr(resp_addr),
        .resp_type(resp_type), .resp_shared(resp_shared), .resp_dirty(resp_dirty),
        .resp_owner_id(resp_owner_id), .resp_timeout(resp_timeout),
        .err_multi_dirty(err_multi_dirty), .err_overrun(err_overrun)
`ifdef SNOOP_COLLECT_PERF_EN
        , .perf_txn_cnt(perf_txn_cnt), .perf_timeout_cnt(perf_timeout_cnt),
        .perf_dirty_cnt(perf_dirty_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus_valid  = 1'b0;
        snp_valid  = '0;
        snp_shared = '0;
        snp_dirty  = '0;
    endtask

    typedef struct {
        logic          bv;
        logic [AW-1:0] addr;
        logic          typ;
        logic [1:0]    gid;
        logic [3:0]    sv, ss, sd;
        logic          e_valid;
        logic [1:0]    e_core;
        logic [AW-1:0] e_addr;
        logic          e_typ, e_sh, e_dt;
        logic [1:0]    e_own;
        logic          e_to;
    } vec_t;

    vec_t vecs[10];

    int            m_phase;
    bit            m_prev_bv;
    int            m_req;
    bit            m_got[4];
    bit            m_sh;
    int            m_ndirty;
    int            m_owner;
    int            m_deadline;
    logic [AW-1:0] m_addr;
    logic          m_type;
    logic          x_valid, x_type, x_sh, x_dt, x_to, x_emd, x_eov;
    logic [1:0]    x_core, x_own;
    logic [AW-1:0] x_addr;
    int unsigned   x_txn, x_tocnt, x_dcnt;

    task automatic model_cycle(input int c);
        bit start;
        int fresh;
        int got_n;
        if (!rst_n) begin
            m_phase = 0; m_prev_bv = 0; m_req = 0; m_sh = 0; m_ndirty = 0; m_owner = 0;
            m_deadline = 0; m_addr = '0; m_type = 0;
            for (int i = 0; i < 4; i++) m_got[i] = 0;
            x_valid = 0; x_type = 0; x_sh = 0; x_dt = 0; x_to = 0; x_emd = 0; x_eov = 0;
            x_core = 0; x_own = 0; x_addr = '0; x_txn = 0; x_tocnt = 0; x_dcnt = 0;
            return;
        end
        if (x_valid) begin
            x_txn++;
            if (x_to) x_tocnt++;
            if (x_dt) x_dcnt++;
        end
        x_valid = 0;
        start = bus_valid && !m_prev_bv;
        m_prev_bv = bus_valid;
        fresh = 0;
        got_n = 0;
        if (m_phase == 0) begin
            if (start) begin
                m_phase = 1; m_req = int'(granted_core_id); m_addr = bus_addr; m_type = bus_type;
                for (int i = 0; i < 4; i++) m_got[i] = 0;
                m_sh = 0; m_ndirty = 0; m_owner = 0; m_deadline = c + 1 + TO;
            end
        end else if (m_phase == 1) begin
            if (start) x_eov = 1;
            for (int i = 0; i < 4; i++) begin
                if (snp_valid[i] && i != m_req && !m_got[i]) begin
                    m_got[i] = 1;
                    if (snp_shared[i]) m_sh = 1;
                    if (snp_dirty[i]) begin
                        if (m_ndirty == 0 && fresh == 0) m_owner = i;
                        fresh++;
                    end
                end
            end
            if (fresh > 0 && (m_ndirty + fresh) > 1) x_emd = 1;
            m_ndirty += fresh;
            for (int i = 0; i < 4; i++) got_n += int'(m_got[i]);
            if (got_n == 3 || c + 1 == m_deadline) begin
                m_phase = 2; x_valid = 1; x_core = 2'(m_req); x_addr = m_addr; x_type = m_type;
                x_sh = m_sh; x_dt = (m_ndirty > 0); x_own = 2'(m_owner); x_to = (got_n != 3);
            end
        end else begin
            if (start) x_eov = 1;
            m_phase = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        bit bv_r;

        vecs[0] = '{1'b1, 64'hA0,   1'b1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 64'h0,    1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[1] = '{1'b1, 64'hA0,   1'b1, 2'd1, 4'b1101, 4'b0100, 4'b0000, 1'b1, 2'd1, 64'hA0,   1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[2] = '{1'b0, 64'h0,    1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 64'hA0,   1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[3] = '{1'b0, 64'h0,    1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 64'hA0,   1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[4] = '{1'b1, 64'h1000, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 64'hA0,   1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[5] = '{1'b1, 64'h1000, 1'b0, 2'd0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd1, 64'hA0,   1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[6] = '{1'b1, 64'h1000, 1'b0, 2'd0, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd1, 64'hA0,   1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[7] = '{1'b0, 64'h0,    1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 64'hA0,   1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[8] = '{1'b0, 64'h0,    1'b0, 2'd0, 4'b0110, 4'b0000, 4'b0000, 1'b1, 2'd0, 64'h1000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0};
        vecs[9] = '{1'b0, 64'h0,    1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 64'h1000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0};

        quiet();
        rst_n = 1'b0; bus_addr = '0; bus_type = 1'b0; granted_core_id = '0;
        tick(); tick();
        `CHK("rst_resp_valid", resp_valid, 0);
        `CHK("rst_resp_addr", resp_addr, 0);
        `CHK("rst_resp_core", resp_core_id, 0);
        `CHK("rst_err_md", err_multi_dirty, 0);
        `CHK("rst_err_ov", err_overrun, 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 10; v++) begin
            bus_valid = vecs[v].bv; bus_addr = vecs[v].addr; bus_type = vecs[v].typ;
            granted_core_id = vecs[v].gid;
            snp_valid = vecs[v].sv; snp_shared = vecs[v].ss; snp_dirty = vecs[v].sd;
            tick();
            $display("vec %0d: resp_valid=%0d core=%0d addr=0x%0h shared=%0d dirty=%0d owner=%0d timeout=%0d",
                     v, resp_valid, resp_core_id, resp_addr, resp_shared, resp_dirty, resp_owner_id, resp_timeout);
            n_checks++;
            if (resp_valid !== vecs[v].e_valid) begin
                n_fail++;
                $display("FAIL vec%0d_valid: got 0x%0h, expected 0x%0h (t=%0t)", v, resp_valid, vecs[v].e_valid, $time);
            end
            `CHK($sformatf("vec%0d_core", v), resp_core_id, vecs[v].e_core);
            `CHK($sformatf("vec%0d_addr", v), resp_addr, vecs[v].e_addr);
            `CHK($sformatf("vec%0d_type", v), resp_type, vecs[v].e_typ);
            `CHK($sformatf("vec%0d_shared", v), resp_shared, vecs[v].e_sh);
            `CHK($sformatf("vec%0d_dirty", v), resp_dirty, vecs[v].e_dt);
            `CHK($sformatf("vec%0d_owner", v), resp_owner_id, vecs[v].e_own);
            `CHK($sformatf("vec%0d_timeout", v), resp_timeout, vecs[v].e_to);
        end
        quiet();
        `CHK("table_err_md", err_multi_dirty, 0);
        `CHK("table_err_ov", err_overrun, 0);

        bus_valid = 1'b1; granted_core_id = 2'd2; bus_addr = 64'h2000; bus_type = 1'b1;
        tick(); cyc = 1;
        bus_valid = 1'b0; snp_valid = 4'b0001; snp_shared = 4'b0001;
        tick(); cyc = 2;
        quiet();
        while (!resp_valid && cyc < 40) begin
            tick(); cyc++;
        end
        $display("timeout txn: response after %0d cycles, timeout=%0d", cyc, resp_timeout);
        `CHK("timeout_latency", cyc, 1 + TO);
        `CHK("timeout_flag", resp_timeout, 1);
        `CHK("timeout_core", resp_core_id, 2);
        `CHK("timeout_shared", resp_shared, 1);
        `CHK("timeout_dirty", resp_dirty, 0);
        tick();
        `CHK("timeout_pulse_len", resp_valid, 0);

        bus_valid = 1'b1; granted_core_id = 2'd0; bus_addr = 64'h3000; bus_type = 1'b0;
        tick();
        bus_valid = 1'b0; snp_valid = 4'b1110; snp_dirty = 4'b1010; snp_shared = 4'b0100;
        tick();
        quiet();
        $display("multi-dirty txn: owner=%0d err_multi_dirty=%0d", resp_owner_id, err_multi_dirty);
        `CHK("md_valid", resp_valid, 1);
        `CHK("md_dirty", resp_dirty, 1);
        `CHK("md_owner", resp_owner_id, 1);
        `CHK("md_shared", resp_shared, 1);
        `CHK("md_timeout", resp_timeout, 0);
        `CHK("md_err", err_multi_dirty, 1);
        tick();
        bus_valid = 1'b1; granted_core_id = 2'd2; bus_addr = 64'h3040;
        tick();
        bus_valid = 1'b0; snp_valid = 4'b1011;
        tick();
        quiet();
        $display("clean txn after multi-dirty: dirty=%0d err_multi_dirty=%0d", resp_dirty, err_multi_dirty);
        `CHK("clean_valid", resp_valid, 1);
        `CHK("clean_dirty", resp_dirty, 0);
        `CHK("clean_owner", resp_owner_id, 0);
        `CHK("md_err_sticky", err_multi_dirty, 1);
        tick();

        bus_valid = 1'b1; granted_core_id = 2'd3; bus_addr = 64'h4000;
        tick();
        bus_valid = 1'b0; snp_valid = 4'b1000; snp_dirty = 4'b1000;
        tick();
        bus_valid = 1'b1; snp_valid = '0; snp_dirty = '0;
        tick();
        `CHK("ov_err", err_overrun, 1);
        snp_valid = 4'b0111;
        tick();
        snp_valid = '0;
        pulses = int'(resp_valid);
        `CHK("ov_core", resp_core_id, 3);
        `CHK("ov_self_dirty_ignored", resp_dirty, 0);
        repeat (5) begin tick(); pulses += int'(resp_valid); end
        bus_valid = 1'b0;
        repeat (3) begin tick(); pulses += int'(resp_valid); end
        $display("overrun txn: %0d response pulses, err_overrun=%0d", pulses, err_overrun);
        `CHK("ov_pulses", pulses, 1);

        bus_valid = 1'b1; granted_core_id = 2'd1; bus_addr = 64'h5000; bus_type = 1'b1;
        tick();
        bus_valid = 1'b0; snp_valid = 4'b0001; snp_shared = 4'b0001;
        tick();
        quiet();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        `CHK("mid_rst_valid", resp_valid, 0);
        `CHK("mid_rst_core", resp_core_id, 0);
        `CHK("mid_rst_addr", resp_addr, 0);
        `CHK("mid_rst_type", resp_type, 0);
        `CHK("mid_rst_shared", resp_shared, 0);
        `CHK("mid_rst_dirty", resp_dirty, 0);
        `CHK("mid_rst_owner", resp_owner_id, 0);
        `CHK("mid_rst_timeout", resp_timeout, 0);
        `CHK("mid_rst_err_md", err_multi_dirty, 0);
        `CHK("mid_rst_err_ov", err_overrun, 0);
        pulses = 0;
        repeat (20) begin tick(); pulses += int'(resp_valid); end
        `CHK("mid_rst_no_resp", pulses, 0);
        bus_valid = 1'b1; granted_core_id = 2'd1; bus_addr = 64'h6000; bus_type = 1'b0;
        tick();
        bus_valid = 1'b0; snp_valid = 4'b1101; snp_dirty = 4'b0100;
        tick();
        quiet();
        $display("post-reset txn: core=%0d addr=0x%0h owner=%0d", resp_core_id, resp_addr, resp_owner_id);
        `CHK("post_rst_valid", resp_valid, 1);
        `CHK("post_rst_core", resp_core_id, 1);
        `CHK("post_rst_addr", resp_addr, 64'h6000);
        `CHK("post_rst_dirty", resp_dirty, 1);
        `CHK("post_rst_owner", resp_owner_id, 2);
        `CHK("post_rst_err_md", err_multi_dirty, 0);
        tick();

        bv_r = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 5) == 0) bv_r = !bv_r;
            bus_valid       = bv_r;
            bus_addr        = {$urandom, $urandom};
            bus_type        = 1'($urandom_range(0, 1));
            granted_core_id = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                snp_valid[i] = ($urandom_range(0, 3) == 0);
                snp_dirty[i] = ($urandom_range(0, 7) == 0);
            end
            snp_shared = 4'($urandom);
            model_cycle(c);
            tick();
            n_checks++;
            if (resp_valid !== x_valid) begin
                n_fail++;
                $display("FAIL rnd_valid: got 0x%0h, expected 0x%0h (t=%0t)", resp_valid, x_valid, $time);
            end
            n_checks++;
            if (err_multi_dirty !== x_emd) begin
                n_fail++;
                $display("FAIL rnd_err_md: got 0x%0h, expected 0x%0h (t=%0t)", err_multi_dirty, x_emd, $time);
            end
            n_checks++;
            if (err_overrun !== x_eov) begin
                n_fail++;
                $display("FAIL rnd_err_ov: got 0x%0h, expected 0x%0h (t=%0t)", err_overrun, x_eov, $time);
            end
            if (x_valid) begin
                $display("rnd txn @%0d: core=%0d addr=0x%0h sh=%0d dt=%0d own=%0d to=%0d",
                         c, x_core, x_addr, x_sh, x_dt, x_own, x_to);
                `CHK("rnd_core", resp_core_id, x_core);
                `CHK("rnd_addr", resp_addr, x_addr);
                `CHK("rnd_type", resp_type, x_type);
                `CHK("rnd_shared", resp_shared, x_sh);
                `CHK("rnd_dirty", resp_dirty, x_dt);
                `CHK("rnd_owner", resp_owner_id, x_own);
                `CHK("rnd_timeout", resp_timeout, x_to);
            end
`ifdef SNOOP_COLLECT_PERF_EN
            `CHK("perf_txn", perf_txn_cnt, x_txn);
            `CHK("perf_timeout", perf_timeout_cnt, x_tocnt);
            `CHK("perf_dirty", perf_dirty_cnt, x_dcnt);
`endif
        end
        quiet();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
